dcache_ctrl: RTL

//  Direct-mapped, write-back, write-allocate data cache between the 3-stage-latched CPU dcache port and main memory.

---
 rtl/dcache_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// A miss evicts a dirty victim, refills one 128-bit line, then replays the latched request.
module dcache_ctrl #(
  parameter int unsigned LINES = 16,
  parameter int unsigned IDX_W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  cpu_addr,
  input  logic         cpu_re,
  input  logic [3:0]   cpu_we,
  input  logic [31:0]  cpu_din,
  output logic [31:0]  cpu_dout,
  output logic         stall,
  output logic         mem_req_valid,
  input  logic         mem_req_ready,
  output logic         mem_req_rw,
  output logic [27:0]  mem_req_addr,
  output logic [127:0] mem_req_data,
  input  logic         mem_resp_valid,
  input  logic [127:0] mem_resp_data
);
  localparam int unsigned TAG_W = 28 - IDX_W;

  typedef enum logic [2:0] {
    S_IDLE, S_WB_REQ, S_FILL_REQ, S_FILL_WAIT, S_REPLAY
  } state_e;

  state_e             state_q;
  logic               req_pending_q;
  logic [31:2]        addr_q;
  logic [3:0]         we_q;
  logic [31:0]        din_q;
  logic [31:0]        dout_q;
  logic [LINES-1:0]   valid_q;
  logic [LINES-1:0]   dirty_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [127:0]       data_q [LINES];

  logic [IDX_W-1:0]   idx_c;
  logic [TAG_W-1:0]   tag_c;
  logic [1:0]         word_c;
  logic [127:0]       line_c;
  logic               hit_c;
  logic               complete_c;
  logic               accept_c;
  logic               is_write_c;
  logic               unused_addr;

  function automatic logic [127:0] merge_line(input logic [127:0] line, input logic [1:0] word,
                                              input logic [3:0] be, input logic [31:0] data);
    logic [127:0] res;
    res = line;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[{word, 2'(b), 3'b000} +: 8] = data[8*b +: 8];
    end
    return res;
  endfunction

  assign idx_c      = addr_q[IDX_W+3:4];
  assign tag_c      = addr_q[31:IDX_W+4];
  assign word_c     = addr_q[3:2];
  assign line_c     = data_q[idx_c];
  assign is_write_c = |we_q;
  assign hit_c      = valid_q[idx_c] && (tag_q[idx_c] == tag_c);

  // REPLAY is a forced hit; every other non-IDLE state holds the CPU off
  assign stall      = (state_q == S_IDLE) ? (req_pending_q && !hit_c) : (state_q != S_REPLAY);
  assign complete_c = req_pending_q && ((state_q == S_IDLE && hit_c) || state_q == S_REPLAY);
  assign accept_c   = !stall && (cpu_re || (|cpu_we));
  assign cpu_dout   = (complete_c && !is_write_c) ? line_c[{word_c, 5'b00000} +: 32] : dout_q;

  assign mem_req_valid = (state_q == S_WB_REQ) || (state_q == S_FILL_REQ);
  assign mem_req_rw    = (state_q == S_WB_REQ);
  assign mem_req_addr  = (state_q == S_WB_REQ) ? {tag_q[idx_c], idx_c} : addr_q[31:4];
  assign mem_req_data  = line_c;
  assign unused_addr   = ^cpu_addr[1:0];

  // Control state, request latch and valid/dirty bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      req_pending_q <= 1'b0;
      addr_q        <= '0;
      we_q          <= '0;
      din_q         <= '0;
      dout_q        <= '0;
      valid_q       <= '0;
      dirty_q       <= '0;
    end else begin
      if (!stall) begin
        req_pending_q <= accept_c;
        if (accept_c) begin
          addr_q <= cpu_addr[31:2];
          we_q   <= cpu_we;
          din_q  <= cpu_din;
        end
      end
      if (complete_c) begin
        if (is_write_c) dirty_q[idx_c] <= 1'b1;
        else            dout_q         <= cpu_dout;
      end
      case (state_q)
        S_IDLE: begin
          if (req_pending_q && !hit_c)
            state_q <= (valid_q[idx_c] && dirty_q[idx_c]) ? S_WB_REQ : S_FILL_REQ;
        end
        S_WB_REQ:   if (mem_req_ready) state_q <= S_FILL_REQ;
        S_FILL_REQ: if (mem_req_ready) state_q <= S_FILL_WAIT;
        S_FILL_WAIT: begin
          if (mem_resp_valid) begin
            valid_q[idx_c] <= 1'b1;
            dirty_q[idx_c] <= 1'b0;
            state_q        <= S_REPLAY;
          end
        end
        S_REPLAY: state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  // Tag and data arrays carry no reset; validity is tracked separately
  always_ff @(posedge clk) begin
    if (state_q == S_FILL_WAIT && mem_resp_valid) begin
      data_q[idx_c] <= mem_resp_data;
      tag_q[idx_c]  <= tag_c;
    end else if (complete_c && is_write_c) begin
      data_q[idx_c] <= merge_line(line_c, word_c, we_q, din_q);
    end
  end
endmodule
